// File: rtl/mdu_pkg.sv
// Shared types for the EX-stage multiply/divide path.
// Op encoding and multiply-controller state enumeration.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_MUL   = 3'd2,
      OP_MADD  = 3'd3,
      OP_MADDU = 3'd4,
      OP_MSUB  = 3'd5,
      OP_MSUBU = 3'd6,
      OP_RSVD  = 3'd7
   } mul_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ACC   = 2'd2,
      ST_DRAIN = 2'd3
   } mul_state_e;

   function automatic logic is_acc(input mul_op_e op);
      return (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_sub(input mul_op_e op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_signed(input mul_op_e op);
      return (op == OP_MULT) || (op == OP_MUL) ||
             (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/mul_ctrl.sv
// EX-stage multiply sequencer: drives the start/ready multiplier,
// performs HI/LO accumulate, issues HI/LO or GPR writes, stalls EX.
module mul_ctrl
   import mdu_pkg::*;
#(
   parameter bit ACC_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   output logic        ex_stall,
   output logic        done,
   input  logic [63:0] hilo_rdata,
   output logic        hilo_we,
   output logic [63:0] hilo_wdata,
   output logic        gpr_we,
   output logic [31:0] gpr_wdata,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_sign,
   output logic        mul_start,
   input  logic [63:0] mul_result,
   input  logic        mul_ready
);

   mul_state_e  state_q, state_d;
   mul_op_e     op_q, op_d;
   logic [63:0] prod_q, prod_d;
   mul_op_e     req_e;
   logic        op_ok;

   assign req_e = mul_op_e'(req_op);
   assign op_ok = (req_e != OP_RSVD) && (ACC_EN || !is_acc(req_e));

   assign mul_a    = rst ? '0 : req_a;
   assign mul_b    = rst ? '0 : req_b;
   assign mul_sign = rst ? 1'b0 : is_signed(req_e);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MULT;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      prod_d     = prod_q;
      ex_stall   = 1'b0;
      done       = 1'b0;
      hilo_we    = 1'b0;
      hilo_wdata = '0;
      gpr_we     = 1'b0;
      gpr_wdata  = '0;
      mul_start  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && !flush) begin
               if (!op_ok) begin
                  done = 1'b1;
               end else if (!mul_ready) begin
                  mul_start = 1'b1;
                  ex_stall  = 1'b1;
                  op_d      = req_e;
                  state_d   = ST_WAIT;
               end else begin
                  // multiplier would ignore the start; hold EX a cycle
                  ex_stall = 1'b1;
               end
            end
         end

         ST_WAIT: begin
            if (flush) begin
               state_d = mul_ready ? ST_IDLE : ST_DRAIN;
            end else if (!mul_ready) begin
               ex_stall = 1'b1;
            end else if (is_acc(op_q)) begin
               ex_stall = 1'b1;
               prod_d   = mul_result;
               state_d  = ST_ACC;
            end else begin
               done    = 1'b1;
               state_d = ST_IDLE;
               if (op_q == OP_MUL) begin
                  gpr_we    = 1'b1;
                  gpr_wdata = mul_result[31:0];
               end else begin
                  hilo_we    = 1'b1;
                  hilo_wdata = mul_result;
               end
            end
         end

         ST_ACC: begin
            state_d = ST_IDLE;
            if (!flush) begin
               hilo_we    = 1'b1;
               hilo_wdata = is_sub(op_q) ? hilo_rdata - prod_q
                                         : hilo_rdata + prod_q;
               done       = 1'b1;
            end
         end

         ST_DRAIN: begin
            ex_stall = req_valid;
            if (mul_ready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      // a reset cycle abandons whatever is in progress
      if (rst) begin
         ex_stall   = 1'b0;
         done       = 1'b0;
         hilo_we    = 1'b0;
         hilo_wdata = '0;
         gpr_we     = 1'b0;
         gpr_wdata  = '0;
         mul_start  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_ctrl.sv
// Scoreboard bench for mul_ctrl with a start/ready multiplier model
// whose ready latency is adjustable.
module tb_mul_ctrl;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        flush;
   logic        ex_stall, done;
   logic [63:0] hilo_rdata;
   logic        hilo_we;
   logic [63:0] hilo_wdata;
   logic        gpr_we;
   logic [31:0] gpr_wdata;
   logic [31:0] mul_a, mul_b;
   logic        mul_sign, mul_start;
   logic [63:0] mul_result;
   logic        mul_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        hwe;
      logic        gwe;
      logic [63:0] hd;
      logic [31:0] gd;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   mul_ctrl #(.ACC_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .flush      (flush),
      .ex_stall   (ex_stall),
      .done       (done),
      .hilo_rdata (hilo_rdata),
      .hilo_we    (hilo_we),
      .hilo_wdata (hilo_wdata),
      .gpr_we     (gpr_we),
      .gpr_wdata  (gpr_wdata),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_sign   (mul_sign),
      .mul_start  (mul_start),
      .mul_result (mul_result),
      .mul_ready  (mul_ready)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // multiplier model: ready pulses dly cycles after an accepted start
   int dly = 1;
   int cnt = 0;
   logic [63:0] pend;
   logic signed [63:0] xa, xb;
   logic [63:0] p_s, p_u, p_now;

   assign xa    = {{32{mul_a[31]}}, mul_a};
   assign xb    = {{32{mul_b[31]}}, mul_b};
   assign p_s   = xa * xb;
   assign p_u   = {32'b0, mul_a} * {32'b0, mul_b};
   assign p_now = mul_sign ? p_s : p_u;

   always @(posedge clk) begin
      if (rst) begin
         mul_ready  <= 1'b0;
         mul_result <= '0;
         cnt        <= 0;
      end else begin
         mul_ready <= 1'b0;
         if (cnt == 1) begin
            mul_ready  <= 1'b1;
            mul_result <= pend;
         end
         if (cnt > 0) cnt <= cnt - 1;
         if (mul_start && !mul_ready) begin
            if (dly <= 1) begin
               mul_ready  <= 1'b1;
               mul_result <= p_now;
            end else begin
               cnt  <= dly - 1;
               pend <= p_now;
            end
         end
      end
   end

   function automatic logic ref_signed(input logic [2:0] op);
      return (op == 3'd0) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
   endfunction

   function automatic logic [63:0] ref_prod(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
      logic signed [63:0] sa, sb2;
      logic [63:0] r;
      sa  = {{32{a[31]}}, a};
      sb2 = {{32{b[31]}}, b};
      if (ref_signed(op)) r = sa * sb2;
      else r = {32'b0, a} * {32'b0, b};
      return r;
   endfunction

   task automatic push_exp(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] h);
      exp_t x;
      logic [63:0] p;
      p = ref_prod(op, a, b);
      x.hwe = 1'b0;
      x.gwe = 1'b0;
      x.hd  = '0;
      x.gd  = '0;
      case (op)
         3'd0, 3'd1: begin x.hwe = 1'b1; x.hd = p; end
         3'd2:       begin x.gwe = 1'b1; x.gd = p[31:0]; end
         3'd3, 3'd4: begin x.hwe = 1'b1; x.hd = h + p; end
         3'd5, 3'd6: begin x.hwe = 1'b1; x.hd = h - p; end
         default: ;
      endcase
      sb.push_back(x);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("start_while_ready", 64'(mul_start & mul_ready), 64'd0);
         chk("write_without_done", 64'((hilo_we | gpr_we) & ~done), 64'd0);
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 64'(done), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("hilo_we", 64'(hilo_we), 64'(e.hwe));
               chk("gpr_we", 64'(gpr_we), 64'(e.gwe));
               chk("done_stall", 64'(ex_stall), 64'd0);
               if (e.hwe) chk("hilo_wdata", hilo_wdata, e.hd);
               if (e.gwe) chk("gpr_wdata", 64'(gpr_wdata), 64'(e.gd));
            end
         end
      end
   end

   // call right after a posedge; leaves the bench right after a posedge
   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] h,
                         input int exp_lat);
      int lat;
      req_valid  = 1'b1;
      req_op     = op;
      req_a      = a;
      req_b      = b;
      hilo_rdata = h;
      push_exp(op, a, b, h);
      @(negedge clk);
      chk("stall_c0", 64'(ex_stall), 64'(op != 3'd7));
      chk("start_c0", 64'(mul_start), 64'(op != 3'd7));
      if (op != 3'd7) chk("sign", 64'(mul_sign), 64'(ref_signed(op)));
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   initial begin
      int n;
      logic saw;
      rst        = 1'b1;
      req_valid  = 1'b1;
      req_op     = 3'd0;
      req_a      = 32'h1234;
      req_b      = 32'h5678;
      flush      = 1'b0;
      hilo_rdata = '0;

      @(negedge clk);
      chk("rst_start", 64'(mul_start), 64'd0);
      chk("rst_stall", 64'(ex_stall), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 1'b0;
      @(posedge clk);
      #1;

      run_op(3'd0, 32'hFFFFFFFE, 32'd3, 64'd0, 1);
      run_op(3'd1, 32'hFFFFFFFE, 32'd3, 64'd0, 1);
      run_op(3'd3, 32'hFFFFFFFF, 32'd5, 64'h10, 2);
      run_op(3'd6, 32'd1, 32'd1, 64'd0, 2);
      run_op(3'd5, 32'hFFFFFFFE, 32'd3, 64'd100, 2);
      run_op(3'd4, 32'hFFFFFFFF, 32'd2, 64'h1, 2);
      run_op(3'd7, 32'd9, 32'd9, 64'd0, 0);
      run_op(3'd2, 32'd7, 32'd6, 64'd0, 1);
      run_op(3'd2, 32'h10000, 32'h10000, 64'd0, 1);

      // flush in WAIT while the product is still three cycles away
      dly        = 3;
      req_valid  = 1'b1;
      req_op     = 3'd0;
      req_a      = 32'd5;
      req_b      = 32'd7;
      @(negedge clk);
      chk("fl_start", 64'(mul_start), 64'd1);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(negedge clk);
      chk("fl_done", 64'(done), 64'd0);
      chk("fl_hilo_we", 64'(hilo_we), 64'd0);
      @(posedge clk);
      #1;
      flush  = 1'b0;
      dly    = 1;
      req_op = 3'd2;
      req_a  = 32'd2;
      req_b  = 32'd3;
      push_exp(3'd2, 32'd2, 32'd3, 64'd0);
      n   = 0;
      saw = 1'b0;
      @(negedge clk);
      while (!mul_start && n < 10) begin
         chk("drain_stall", 64'(ex_stall), 64'd1);
         if (mul_ready) saw = 1'b1;
         n++;
         @(negedge clk);
      end
      chk("drain_cycles", 64'(n), 64'd2);
      chk("stale_ready_seen", 64'(saw), 64'd1);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("post_drain_lat", 64'(n), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;

      // reset arriving while in ACC
      req_valid  = 1'b1;
      req_op     = 3'd3;
      req_a      = 32'd2;
      req_b      = 32'd3;
      hilo_rdata = 64'd1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("racc_hilo_we", 64'(hilo_we), 64'd0);
      chk("racc_done", 64'(done), 64'd0);
      chk("racc_stall", 64'(ex_stall), 64'd0);
      chk("racc_wdata", hilo_wdata, 64'd0);
      chk("racc_start", 64'(mul_start), 64'd0);
      chk("racc_mul_a", 64'(mul_a), 64'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_hilo_we", 64'(hilo_we), 64'd0);
      chk("post_rst_done", 64'(done), 64'd0);
      @(posedge clk);
      #1;

      run_op(3'd1, 32'd3, 32'd4, 64'd0, 1);
      repeat (2) @(posedge clk);
      chk("sb_left", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Sequencing controller for the EX-stage multiply path. It accepts a multiply-class instruction from EX and drives the 2-cycle start/ready multiplier that sits beside it. It performs HI/LO accumulate for MADD/MSUB variants, issues the HI/LO or GPR write, and stalls EX until the operation retires. It also handles pipeline flush, including draining a multiplier operation that is already in flight.

## Interface
Parameters:
- ACC_EN, 1, enables MADD/MADDU/MSUB/MSUBU; when 0, ops 3–6 behave as reserved op 7.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  EX holds a multiply-class op; held stable while ex_stall=1.
- req_op  in  3  0 MULT, 1 MULTU, 2 MUL, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 reserved.
- req_a, req_b  in  32  operands; held stable while ex_stall=1.
- flush  in  1  kills the current op (exception or redirect).
- ex_stall  out  1  EX must hold.
- done  out  1  one-cycle pulse when the op retires.
- hilo_rdata  in  64  current architectural {HI,LO}, with forwarding done upstream.
- hilo_we  out  1  HI/LO write strobe.
- hilo_wdata  out  64  {HI,LO} write data.
- gpr_we  out  1  GPR write strobe (MUL only).
- gpr_wdata  out  32  GPR write data.
- mul_a, mul_b  out  32  multiplier operands, passed through from req_a and req_b.
- mul_sign  out  1  signed multiply; 1 for ops 0, 2, 3, 5.
- mul_start  out  1  multiplier start.
- mul_result  in  64  multiplier product; valid when mul_ready=1.
- mul_ready  in  1  one-cycle pulse, one cycle after an accepted start.

## Operation
- States: IDLE, WAIT, ACC, DRAIN.
- IDLE
  - req_valid && !flush && op valid: mul_start=1, ex_stall=1, go to WAIT.
  - Op 7: done=1, no start, no writes, stay in IDLE.
  - flush: mul_start=0.
- WAIT
  - ex_stall=1 until retire.
  - mul_ready && non-accumulate op: retire this cycle.
    - MULT/MULTU: hilo_we=1, hilo_wdata=mul_result.
    - MUL: gpr_we=1, gpr_wdata=mul_result[31:0], HI/LO untouched.
    - done=1, ex_stall=0, go to IDLE.
  - mul_ready && accumulate op: latch prod_q=mul_result, go to ACC.
- ACC
  - hilo_wdata = hilo_rdata ± prod_q, modulo 2^64; signedness affects only the product.
  - hilo_we=1, done=1, ex_stall=0, go to IDLE.
- DRAIN
  - Discards an in-flight product.
  - ex_stall=req_valid, no start.
  - On mul_ready: go to IDLE with no writes.
- Flush (overrides everything; never produces done, hilo_we or gpr_we):
  - In WAIT with mul_ready=0: go to DRAIN.
  - In WAIT with mul_ready=1: go to IDLE.
  - In ACC: go to IDLE.
- Write strobes and done are combinational from state plus mul_ready; prod_q and state are registered.

## Timing
- Reset: state IDLE, prod_q=0, all outputs 0.
  - Reset mid-operation abandons the op with no write.
  - The multiplier shares rst, so no drain is needed.
- Latency, counted from the start cycle (c0):
  - MULT/MULTU/MUL: done in c1.
  - Accumulate ops: done in c2.
  - Op 7: done in c0.
- Back-to-back ops: the next start is issued in the cycle after done.
  - The multiplier's ready has already dropped by then, so the start is accepted.
- mul_start is never asserted while mul_ready=1 or while in DRAIN; the multiplier ignores start while ready is high.
- hilo_rdata is sampled in the ACC cycle.

## Structure
- Shared package mdu_pkg: mul_op_e (3-bit op encoding), mul_state_e.
- Single module, no sub-module.
- The multiplier is a sibling instance connected by the EX-stage wrapper.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → start c0, done and hilo_we in c1, hilo_wdata=0xFFFFFFFF_FFFFFFFA, ex_stall=1 in c0 only.
- MULTU a=0xFFFFFFFE, b=3 → hilo_wdata=0x00000002_FFFFFFFA.
- MADD, hilo_rdata=0x10, a=0xFFFFFFFF, b=5 → done in c2, hilo_wdata=0x00000000_0000000B.
- MSUBU, hilo_rdata=0, a=1, b=1 → hilo_wdata=0xFFFFFFFF_FFFFFFFF (wrap).
- MUL 7×6 then MUL 0x10000×0x10000 back-to-back → gpr_wdata=42, then 0; second start in the cycle after the first done; no hilo_we.
- Flush in WAIT with mul_ready delayed 3 cycles by the model → DRAIN, new req stalled, no writes, start only after the stale ready. Separately, rst during ACC → no hilo_we, all outputs 0.
